// File: rtl/frame_rx_parser.sv
// frame_rx_parser: byte-stream frame receiver.
// Frame format: SOF_BYTE, length L (1..MAX_LEN), L payload bytes, checksum byte.
// The checksum byte must equal (L + sum of payload bytes) mod 256.
// Payload bytes are forwarded through a one-entry output register as they arrive.
// The frame verdict is signalled by a one-cycle frame_done or frame_err pulse
// after the checksum byte. Forwarded bytes are never retracted.
//
// Handshake rules, applied to both ports:
//   - A transfer happens on a rising clk edge where valid=1 and ready=1.
//   - The upstream side keeps in_valid/in_data until the byte is taken.
//   - The output register keeps out_valid/out_data stable while out_ready=0.
//   - in_ready depends on out_ready only in PAYLOAD, where a new byte may be
//     loaded in the same cycle that the held byte drains.
//
// dbg_state exposes the FSM state. Its encoding is IDLE=0, LEN=1, PAYLOAD=2, CHK=3.

module frame_rx_parser #(
    parameter logic [7:0]  SOF_BYTE = 8'hA5,
    parameter int unsigned MAX_LEN  = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_done,
    output logic       frame_err,
    output logic [7:0] frame_len,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LEN     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CHK     = 2'd3
    } state_e;

    // Upper length bound as a byte, so the comparison stays 8 bits wide.
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_e     state_q,     state_d;
    logic [7:0] count_q,     count_d;      // payload bytes still expected
    logic [7:0] csum_q,      csum_d;       // running checksum, wraps mod 256
    logic [7:0] len_q,       len_d;        // length of the frame in flight
    logic [7:0] out_data_q,  out_data_d;
    logic       out_valid_q, out_valid_d;
    logic       done_q,      done_d;
    logic       err_q,       err_d;
    logic [7:0] frame_len_q, frame_len_d;

    logic in_fire;
    logic len_ok;

    // Accept input except during reset.
    // In PAYLOAD, also require that the output register is free, or that it drains this cycle.
    assign in_ready = rst_n && ((state_q != ST_PAYLOAD) || !out_valid_q || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign len_ok   = (in_data != 8'd0) && (in_data <= MAX_LEN_B);

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign frame_len  = frame_len_q;
    assign dbg_state  = state_q;

    // State register and datapath registers.
    // Asynchronous reset aborts any frame without a pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            count_q     <= 8'd0;
            csum_q      <= 8'd0;
            len_q       <= 8'd0;
            out_data_q  <= 8'd0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            frame_len_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            csum_q      <= csum_d;
            len_q       <= len_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
            frame_len_q <= frame_len_d;
        end
    end

    // Next-state and datapath update.
    // Pulses default low, and the output register drains whenever out_ready is high.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        csum_d      = csum_q;
        len_d       = len_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q && !out_ready;
        done_d      = 1'b0;
        err_d       = 1'b0;
        frame_len_d = frame_len_q;

        case (state_q)
            ST_IDLE: begin
                // Bytes other than the marker are noise between frames.
                if (in_fire && (in_data == SOF_BYTE)) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (in_fire) begin
                    if (len_ok) begin
                        count_d = in_data;
                        csum_d  = in_data;
                        len_d   = in_data;
                        state_d = ST_PAYLOAD;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_PAYLOAD: begin
                // A marker value here is data.
                // in_ready already guarantees room in the output register.
                if (in_fire) begin
                    out_data_d  = in_data;
                    out_valid_d = 1'b1;
                    csum_d      = csum_q + in_data;
                    count_d     = count_q - 8'd1;
                    if (count_q == 8'd1) begin
                        state_d = ST_CHK;
                    end
                end
            end
            ST_CHK: begin
                if (in_fire) begin
                    if (in_data == csum_q) begin
                        done_d      = 1'b1;
                        frame_len_d = len_q;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The two frame verdicts are mutually exclusive.
    a_one_verdict: assert property (@(posedge clk) disable iff (!rst_n)
        !(frame_done && frame_err));

    // A stalled output byte stays put until the downstream side takes it.
    a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));

    // PAYLOAD always has at least one byte outstanding.
    a_count_live: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == ST_PAYLOAD) |-> (count_q != 8'd0));

endmodule

// File: tb/tb_frame_rx_parser.sv
// Bench for frame_rx_parser.
// Drives byte streams through the parser and compares the forwarded bytes,
// the frame verdicts and frame_len against a frame-level reference model.
// Timing: the clock period is 10. Inputs change 2 time units after each rising
// edge. Outputs are sampled 8 time units after each rising edge.

module tb_frame_rx_parser;

    localparam logic [7:0] SOF     = 8'hA5;
    localparam int         MAX_LEN = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       frame_done;
    logic       frame_err;
    logic [7:0] frame_len;
    logic [1:0] dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;

    // Scoreboard state.
    // Each verdict entry is {is_done, frame_len}; an error is recorded as {0, 00}.
    logic [7:0] stim_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [8:0] exp_evt_q[$];
    logic [8:0] got_evt_q[$];
    logic [7:0] exp_frame_len;
    bit         rdy_rand = 1'b0;
    bit         mon_hold = 1'b0;
    logic [7:0] mon_data;

    frame_rx_parser #(.SOF_BYTE(SOF), .MAX_LEN(MAX_LEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .frame_len  (frame_len),
        .dbg_state  (dbg_state)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    // Random downstream backpressure, active only when a test enables it.
    always begin
        @(posedge clk);
        #2;
        if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: collects transferred bytes and verdict pulses.
    // It also checks that a stalled output byte is held stable.
    always begin
        @(posedge clk);
        #8;
        if (rst_n === 1'b1) begin
            if (mon_hold) begin
                tests_run++;
                if (out_valid !== 1'b1 || out_data !== mon_data) begin
                    tests_failed++;
                    $display("FAIL hold_stable: out_valid=%0b out_data=%02h, required 1 / %02h",
                             out_valid, out_data, mon_data);
                end
            end
            if (frame_done === 1'b1 || frame_err === 1'b1) begin
                tests_run++;
                if (frame_done === 1'b1 && frame_err === 1'b1) begin
                    tests_failed++;
                    $display("FAIL dual_pulse: frame_done=1 frame_err=1, required at most one");
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) got_q.push_back(out_data);
            if (frame_done === 1'b1) got_evt_q.push_back({1'b1, frame_len});
            if (frame_err === 1'b1)  got_evt_q.push_back({1'b0, 8'h00});
            mon_hold = (out_valid === 1'b1 && out_ready === 1'b0);
            mon_data = out_data;
        end else begin
            mon_hold = 1'b0;
        end
    end

    // Reference model.
    // It parses stim_q frame by frame using the frame rules.
    function automatic void model();
        int i;
        int len;
        int sum;
        i = 0;
        while (i < stim_q.size()) begin
            if (stim_q[i] != SOF) begin
                i++;
                continue;
            end
            if (i + 1 >= stim_q.size()) break;
            len = int'(stim_q[i+1]);
            i += 2;
            if (len == 0 || len > MAX_LEN) begin
                exp_evt_q.push_back({1'b0, 8'h00});
                continue;
            end
            sum = len;
            for (int k = 0; k < len && i < stim_q.size(); k++) begin
                exp_q.push_back(stim_q[i]);
                sum += int'(stim_q[i]);
                i++;
            end
            if (i >= stim_q.size()) break;
            if (stim_q[i] == 8'(sum % 256)) begin
                exp_evt_q.push_back({1'b1, 8'(len)});
                exp_frame_len = 8'(len);
            end else begin
                exp_evt_q.push_back({1'b0, 8'h00});
            end
            i++;
        end
    endfunction

    // Appends a frame to stim_q.
    // An illegal length is followed by nothing, because the parser resyncs on it.
    function automatic void add_frame(input int len, input bit good);
        int sum;
        logic [7:0] b;
        stim_q.push_back(SOF);
        stim_q.push_back(8'(len));
        if (len == 0 || len > MAX_LEN) return;
        sum = len;
        for (int k = 0; k < len; k++) begin
            b = ($urandom_range(0, 7) == 0) ? SOF : 8'($urandom_range(0, 255));
            stim_q.push_back(b);
            sum += int'(b);
        end
        b = 8'(sum % 256);
        if (!good) b = b ^ 8'($urandom_range(1, 255));
        stim_q.push_back(b);
    endfunction

    // Driver: presents one byte until it is taken, and reports the cycles spent.
    task automatic send_byte(input logic [7:0] b, output int waited);
        bit acc;
        acc = 1'b0;
        waited = 0;
        in_data = b;
        in_valid = 1'b1;
        while (!acc) begin
            #6;
            acc = (in_ready === 1'b1);
            @(posedge clk);
            #2;
            waited++;
            if (!acc && waited >= 300) begin
                tests_run++;
                tests_failed++;
                $display("FAIL in_timeout: byte %02h not taken after %0d cycles, required acceptance", b, waited);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_stream(input bit gaps);
        int w;
        for (int i = 0; i < stim_q.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) begin
                    @(posedge clk);
                    #2;
                end
            end
            send_byte(stim_q[i], w);
        end
    endtask

    // Lets the output register empty and any final pulse pass the monitor.
    task automatic drain();
        int n;
        bit empty;
        n = 0;
        empty = 1'b0;
        rdy_rand = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b0;
        while (!empty && n < 100) begin
            #6;
            empty = (out_valid === 1'b0);
            @(posedge clk);
            #2;
            n++;
        end
        repeat (2) begin
            @(posedge clk);
            #2;
        end
        tests_run++;
        if (!empty) begin
            tests_failed++;
            $display("FAIL drain_timeout: out_valid still %0b after %0d cycles, required 0", out_valid, n);
        end
    endtask

    task automatic start_test();
        stim_q.delete();
        exp_q.delete();
        got_q.delete();
        exp_evt_q.delete();
        got_evt_q.delete();
        rdy_rand = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        tests_run++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00 || frame_done !== 1'b0 ||
            frame_err !== 1'b0 || frame_len !== 8'h00 || dbg_state !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_state: rdy=%0b ov=%0b od=%02h done=%0b err=%0b len=%02h st=%0d, required 0 0 00 0 0 00 0",
                     in_ready, out_valid, out_data, frame_done, frame_err, frame_len, dbg_state);
        end
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1 || dbg_state !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_release: in_ready=%0b state=%0d, required 1 / 0", in_ready, dbg_state);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic test_basic();
        int bad;
        start_test();
        stim_q = '{8'hA5, 8'h03, 8'h10, 8'h20, 8'h30, 8'h63};
        model();
        send_stream(1'b0);
        drain();
        bad = (got_q.size() != exp_q.size());
        foreach (exp_q[i]) if (i < got_q.size() && got_q[i] !== exp_q[i]) bad++;
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL basic_bytes: got %0d bytes (%0d wrong), required %0d", got_q.size(), bad, exp_q.size());
        end
        tests_run++;
        if (got_evt_q.size() != 1 || got_evt_q[0] !== 9'h103) begin
            tests_failed++;
            $display("FAIL basic_done: %0d verdicts, first %03h, required 1 verdict 103", got_evt_q.size(),
                     (got_evt_q.size() > 0) ? got_evt_q[0] : 9'h000);
        end
        tests_run++;
        if (frame_len !== 8'h03) begin
            tests_failed++;
            $display("FAIL basic_len: frame_len=%02h, required 03", frame_len);
        end
    endtask

    task automatic test_bad_checksum();
        int bad;
        start_test();
        stim_q = '{8'hA5, 8'h02, 8'hFF, 8'h01, 8'h00};
        model();
        send_stream(1'b0);
        drain();
        bad = (got_q.size() != exp_q.size());
        foreach (exp_q[i]) if (i < got_q.size() && got_q[i] !== exp_q[i]) bad++;
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL badchk_bytes: got %0d bytes (%0d wrong), required %0d", got_q.size(), bad, exp_q.size());
        end
        tests_run++;
        if (got_evt_q.size() != 1 || got_evt_q[0] !== 9'h000) begin
            tests_failed++;
            $display("FAIL badchk_err: %0d verdicts, required exactly one error", got_evt_q.size());
        end
        tests_run++;
        if (frame_len !== exp_frame_len) begin
            tests_failed++;
            $display("FAIL badchk_len: frame_len=%02h, required %02h", frame_len, exp_frame_len);
        end
    endtask

    task automatic test_length_bounds();
        int bad;
        start_test();
        add_frame(0, 1'b1);
        add_frame(MAX_LEN + 1, 1'b1);
        add_frame(MAX_LEN, 1'b1);
        stim_q.push_back(8'hA5);
        stim_q.push_back(8'h02);
        stim_q.push_back(8'hF0);
        stim_q.push_back(8'h20);
        stim_q.push_back(8'h12);
        model();
        send_stream(1'b0);
        drain();
        bad = (got_q.size() != exp_q.size());
        foreach (exp_q[i]) if (i < got_q.size() && got_q[i] !== exp_q[i]) bad++;
        tests_run++;
        if (bad != 0 || got_q.size() != MAX_LEN + 2) begin
            tests_failed++;
            $display("FAIL bounds_bytes: got %0d bytes (%0d wrong), required %0d", got_q.size(), bad, MAX_LEN + 2);
        end
        bad = (got_evt_q.size() != exp_evt_q.size());
        foreach (exp_evt_q[i]) if (i < got_evt_q.size() && got_evt_q[i] !== exp_evt_q[i]) bad++;
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL bounds_verdicts: got %0d verdicts (%0d wrong), required %0d", got_evt_q.size(), bad, exp_evt_q.size());
        end
        tests_run++;
        if (frame_len !== 8'h02) begin
            tests_failed++;
            $display("FAIL bounds_len: frame_len=%02h, required 02", frame_len);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        int w;
        start_test();
        stim_q = '{8'h00, 8'hA5, 8'hA5, 8'h01, 8'hA5, 8'hA6, 8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        model();
        for (int i = 0; i < 9; i++) send_byte(stim_q[i], w);
        // The first payload byte is now held, and the downstream side stalls for 3 cycles.
        out_ready = 1'b0;
        in_data = 8'h22;
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #6;
            tests_run++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'h11) begin
                tests_failed++;
                $display("FAIL stall_hold: cycle %0d in_ready=%0b out_valid=%0b out_data=%02h, required 0 1 11",
                         c, in_ready, out_valid, out_data);
            end
            @(posedge clk);
            #2;
        end
        out_ready = 1'b1;
        for (int i = 9; i < stim_q.size(); i++) send_byte(stim_q[i], w);
        drain();
        bad = (got_q.size() != exp_q.size());
        foreach (exp_q[i]) if (i < got_q.size() && got_q[i] !== exp_q[i]) bad++;
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL bp_bytes: got %0d bytes (%0d wrong), required %0d", got_q.size(), bad, exp_q.size());
        end
        bad = (got_evt_q.size() != exp_evt_q.size());
        foreach (exp_evt_q[i]) if (i < got_evt_q.size() && got_evt_q[i] !== exp_evt_q[i]) bad++;
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL bp_verdicts: got %0d verdicts (%0d wrong), required %0d", got_evt_q.size(), bad, exp_evt_q.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        int w;
        start_test();
        send_byte(8'hA5, w);
        send_byte(8'h03, w);
        out_ready = 1'b0;
        send_byte(8'h10, w);
        rst_n = 1'b0;
        exp_frame_len = 8'h00;
        #1;
        tests_run++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00 || frame_done !== 1'b0 ||
            frame_err !== 1'b0 || frame_len !== 8'h00 || dbg_state !== 2'd0) begin
            tests_failed++;
            $display("FAIL midreset_clear: rdy=%0b ov=%0b od=%02h done=%0b err=%0b len=%02h st=%0d, required 0 0 00 0 0 00 0",
                     in_ready, out_valid, out_data, frame_done, frame_err, frame_len, dbg_state);
        end
        repeat (2) begin
            @(posedge clk);
            #2;
        end
        rst_n = 1'b1;
        out_ready = 1'b1;
        stim_q = '{8'hA5, 8'h01, 8'h07, 8'h08};
        model();
        send_stream(1'b0);
        drain();
        bad = (got_q.size() != exp_q.size());
        foreach (exp_q[i]) if (i < got_q.size() && got_q[i] !== exp_q[i]) bad++;
        tests_run++;
        if (bad != 0 || got_q.size() != 1) begin
            tests_failed++;
            $display("FAIL midreset_bytes: got %0d bytes (%0d wrong), required 1", got_q.size(), bad);
        end
        tests_run++;
        if (got_evt_q.size() != 1 || got_evt_q[0] !== 9'h101 || frame_len !== 8'h01) begin
            tests_failed++;
            $display("FAIL midreset_done: %0d verdicts, frame_len=%02h, required 1 verdict with frame_len 01",
                     got_evt_q.size(), frame_len);
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        int len1;
        int w;
        int sof2_wait;
        start_test();
        len1 = $urandom_range(1, 8);
        add_frame(len1, 1'b1);
        add_frame($urandom_range(1, 8), 1'b1);
        model();
        sof2_wait = 0;
        for (int i = 0; i < stim_q.size(); i++) begin
            send_byte(stim_q[i], w);
            if (i == len1 + 3) sof2_wait = w;
        end
        drain();
        tests_run++;
        if (sof2_wait != 1) begin
            tests_failed++;
            $display("FAIL b2b_sof: second SOF took %0d cycles, required 1", sof2_wait);
        end
        bad = (got_evt_q.size() != 2);
        foreach (exp_evt_q[i]) if (i < got_evt_q.size() && got_evt_q[i] !== exp_evt_q[i]) bad++;
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL b2b_done: got %0d verdicts (%0d wrong), required 2 frame_done", got_evt_q.size(), bad);
        end
        bad = (got_q.size() != exp_q.size());
        foreach (exp_q[i]) if (i < got_q.size() && got_q[i] !== exp_q[i]) bad++;
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL b2b_bytes: got %0d bytes (%0d wrong), required %0d", got_q.size(), bad, exp_q.size());
        end
    endtask

    task automatic test_random();
        int bad;
        int kind;
        logic [7:0] noise;
        for (int r = 0; r < 4; r++) begin
            start_test();
            for (int f = 0; f < 6; f++) begin
                repeat ($urandom_range(0, 2)) begin
                    noise = 8'($urandom_range(0, 255));
                    if (noise == SOF) noise = 8'h00;
                    stim_q.push_back(noise);
                end
                kind = $urandom_range(0, 9);
                if (kind == 0)      add_frame(0, 1'b1);
                else if (kind == 1) add_frame($urandom_range(MAX_LEN + 1, 255), 1'b1);
                else if (kind == 2) add_frame($urandom_range(1, MAX_LEN), $urandom_range(0, 3) != 0);
                else                add_frame($urandom_range(1, 12), $urandom_range(0, 3) != 0);
            end
            model();
            rdy_rand = 1'b1;
            send_stream(1'b1);
            drain();
            bad = (got_q.size() != exp_q.size());
            foreach (exp_q[i]) if (i < got_q.size() && got_q[i] !== exp_q[i]) bad++;
            tests_run++;
            if (bad != 0) begin
                tests_failed++;
                $display("FAIL rand_bytes[%0d]: got %0d bytes (%0d wrong), required %0d", r, got_q.size(), bad, exp_q.size());
            end
            bad = (got_evt_q.size() != exp_evt_q.size());
            foreach (exp_evt_q[i]) if (i < got_evt_q.size() && got_evt_q[i] !== exp_evt_q[i]) bad++;
            tests_run++;
            if (bad != 0) begin
                tests_failed++;
                $display("FAIL rand_verdicts[%0d]: got %0d verdicts (%0d wrong), required %0d", r, got_evt_q.size(), bad, exp_evt_q.size());
            end
            tests_run++;
            if (frame_len !== exp_frame_len) begin
                tests_failed++;
                $display("FAIL rand_len[%0d]: frame_len=%02h, required %02h", r, frame_len, exp_frame_len);
            end
        end
    endtask

    // Test sequence.
    initial begin
        rst_n = 1'b0;
        in_data = 8'h00;
        in_valid = 1'b0;
        out_ready = 1'b1;
        exp_frame_len = 8'h00;
        repeat (2) @(posedge clk);
        #2;
        test_reset();
        test_basic();
        test_bad_checksum();
        test_length_bounds();
        test_backpressure();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
